// File: rtl/n8_pkg.sv
`default_nettype none
// ============================================================================
// Package  : n8_pkg
// Purpose  : Shared types and default timing constants for the n8 controller
//            move conditioner (direction FSM states, direction codes).
// Revision : 1.0 - initial release
// ============================================================================
package n8_pkg;

    // Direction FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HOLD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } n8_state_t;

    // Latched direction; the encoding order is also the press priority
    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_t;

    // Default timings for a 50 MHz clock
    localparam int DEB_10MS   = 500000;
    localparam int HOLD_500MS = 25000000;
    localparam int REP_100MS  = 5000000;

    // One-hot pulse vector, bit index equals the direction code
    function automatic logic [3:0] dir_onehot(input dir_t d);
        dir_onehot = 4'b0001 << d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/n8_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : n8_btn_debounce
// Purpose  : Single-button debouncer. The stable level follows the input once
//            DEBOUNCE_CYC consecutive samples disagree with it; a rising
//            change of the stable level gives a one-cycle pulse.
// Ports    : clk        - system clock
//            reset_n    - asynchronous active-low reset
//            in         - raw button level (already synchronous to clk)
//            level      - debounced level
//            rise_pulse - one-cycle pulse on debounced rising edge
// Revision : 1.0 - initial release
// ============================================================================
module n8_btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic level,
    output logic rise_pulse
);

    localparam int                c_CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

    logic               r_samp;
    logic               r_level;
    logic               r_rise;
    logic [c_CNT_W-1:0] r_cnt;

    // The input is registered once so that a level held from cycle 0
    // produces its pulse in cycle DEBOUNCE_CYC, aligned with the direction path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_samp  <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_samp <= in;
            r_rise <= 1'b0;
            if (r_samp == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_samp;
                r_rise  <= r_samp;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_rise;

endmodule
`default_nettype wire

// File: rtl/n8_move_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : n8_move_conditioner
// Purpose  : Turns raw n8 controller levels into one-cycle command pulses:
//            debounced, one direction at a time (U > D > L > R), with timed
//            auto-repeat while a direction is held. A and start are
//            debounced independently and pulse once per press.
// Ports    : clk, reset_n (async, active-low)
//            up/down/left/right/a/start - raw levels from the n8 driver
//            repeat_en   - 1 allows auto-repeat
//            shft_U/D/L/R, press_A, press_start - one-cycle pulses
//            dir_active  - high while a direction is accepted and held
// Revision : 1.0 - initial release
// ============================================================================
module n8_move_conditioner
    import n8_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEB_10MS,
    parameter int HOLD_CYC     = HOLD_500MS,
    parameter int REPEAT_CYC   = REP_100MS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    input  logic a,
    input  logic start,
    input  logic repeat_en,
    output logic shft_U,
    output logic shft_D,
    output logic shft_L,
    output logic shft_R,
    output logic press_A,
    output logic press_start,
    output logic dir_active
);

    localparam int c_MAX_DH = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
    localparam int c_MAX    = (c_MAX_DH > REPEAT_CYC) ? c_MAX_DH : REPEAT_CYC;
    localparam int c_CNT_W  = $clog2(c_MAX);

    localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_REP_LAST  = c_CNT_W'(REPEAT_CYC - 1);

    if (DEBOUNCE_CYC < 2 || HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_params
        $error("n8_move_conditioner: DEBOUNCE_CYC, HOLD_CYC and REPEAT_CYC must all be >= 2");
    end

    n8_state_t          r_state;
    dir_t               r_dir;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_pulse;
    logic               r_dir_active;

    logic [3:0] w_dirs;
    logic       w_held;
    logic       w_any;
    dir_t       w_prio;
    logic       w_pulsed_last;

    assign w_dirs        = {right, left, down, up};
    assign w_held        = w_dirs[r_dir];
    assign w_any         = |w_dirs;
    assign w_pulsed_last = |r_pulse;

    always_comb begin
        w_prio = DIR_R;
        if (up)        w_prio = DIR_U;
        else if (down) w_prio = DIR_D;
        else if (left) w_prio = DIR_L;
    end

    // In HOLD and REPEAT the counter does not advance in the cycle the pulse
    // is visible, so HOLD_CYC / REPEAT_CYC are the idle cycles between pulses.
    // Entering HOLD from RELEASE_DB has no pulse and counts immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_U;
            r_cnt        <= '0;
            r_pulse      <= '0;
            r_dir_active <= 1'b0;
        end else begin
            r_pulse <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_dir   <= w_prio;
                        r_state <= ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_held) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_pulse      <= dir_onehot(r_dir);
                        r_state      <= ST_HOLD;
                        r_cnt        <= '0;
                        r_dir_active <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!w_held) begin
                        r_state <= ST_RELEASE_DB;
                        r_cnt   <= '0;
                    end else if (!repeat_en) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_pulse <= dir_onehot(r_dir);
                        r_state <= ST_REPEAT;
                        r_cnt   <= '0;
                    end else if (!w_pulsed_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!w_held) begin
                        r_state <= ST_RELEASE_DB;
                        r_cnt   <= '0;
                    end else if (!repeat_en) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_REP_LAST) begin
                        r_pulse <= dir_onehot(r_dir);
                        r_cnt   <= '0;
                    end else if (!w_pulsed_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_held) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_state      <= ST_IDLE;
                        r_cnt        <= '0;
                        r_dir_active <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                    r_dir_active <= 1'b0;
                end
            endcase
        end
    end

    logic w_unused_a_level;
    logic w_unused_start_level;

    n8_btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (a),
        .level      (w_unused_a_level),
        .rise_pulse (press_A)
    );

    n8_btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_start (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (start),
        .level      (w_unused_start_level),
        .rise_pulse (press_start)
    );

    assign shft_U     = r_pulse[DIR_U];
    assign shft_D     = r_pulse[DIR_D];
    assign shft_L     = r_pulse[DIR_L];
    assign shft_R     = r_pulse[DIR_R];
    assign dir_active = r_dir_active;

endmodule
`default_nettype wire

// File: tb/tb_n8_move_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_n8_move_conditioner
// Purpose  : Self-checking bench for n8_move_conditioner with short timings
//            (DEBOUNCE 4, HOLD 10, REPEAT 3). A timestamp-based reference
//            model predicts every output each cycle; directed scenarios also
//            compare pulse-time masks against hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n8_move_conditioner;

    localparam int DEB = 4;
    localparam int HLD = 10;
    localparam int REP = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic a = 1'b0, start = 1'b0, repeat_en = 1'b1;
    logic shft_U, shft_D, shft_L, shft_R, press_A, press_start, dir_active;

    logic [6:0] obs;
    assign obs = {shft_U, shft_D, shft_L, shft_R, press_A, press_start, dir_active};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    n8_move_conditioner #(
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HLD),
        .REPEAT_CYC   (REP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .a           (a),
        .start       (start),
        .repeat_en   (repeat_en),
        .shft_U      (shft_U),
        .shft_D      (shft_D),
        .shft_L      (shft_L),
        .shft_R      (shft_R),
        .press_A     (press_A),
        .press_start (press_start),
        .dir_active  (dir_active)
    );

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 press debounce, 2 held, 3 release debounce.
    // Times are absolute edge indices; m_dl is the edge of the next repeat.
    int         m_phase = 0;
    int         m_dir   = 0;
    int         m_t0    = 0;
    int         m_dl    = 0;
    logic [1:0] b_lvl   = '0;
    logic [DEB-1:0] b_hist [2];
    logic [6:0] exp_o   = '0;

    task automatic model_step();
        logic [3:0] dv;
        logic [3:0] sh;
        logic [1:0] bin;
        logic [1:0] rise;
        logic       held;
        dv   = {right, left, down, up};
        bin  = {start, a};
        sh   = '0;
        rise = '0;
        if (!reset_n) begin
            m_phase   = 0;
            m_dir     = 0;
            b_lvl     = '0;
            b_hist[0] = '0;
            b_hist[1] = '0;
        end else begin
            held = dv[m_dir];
            case (m_phase)
                0: if (dv != 4'b0) begin
                    m_dir   = up ? 0 : down ? 1 : left ? 2 : 3;
                    m_phase = 1;
                    m_t0    = cyc;
                end
                1: if (!held) begin
                    m_phase = 0;
                end else if (cyc == m_t0 + DEB) begin
                    sh[m_dir] = 1'b1;
                    m_phase   = 2;
                    m_dl      = cyc + HLD + 1;
                end
                2: if (!held) begin
                    m_phase = 3;
                    m_t0    = cyc;
                end else if (repeat_en && cyc == m_dl) begin
                    sh[m_dir] = 1'b1;
                    m_dl      = cyc + REP + 1;
                end
                default: if (held) begin
                    m_phase = 2;
                    m_dl    = cyc + HLD;
                end else if (cyc == m_t0 + DEB) begin
                    m_phase = 0;
                end
            endcase
            // A window of the last DEB samples that all disagree with the
            // stable level flips it.
            for (int k = 0; k < 2; k++) begin
                if (b_hist[k] == {DEB{1'b1}} && !b_lvl[k]) begin
                    b_lvl[k] = 1'b1;
                    rise[k]  = 1'b1;
                end else if (b_hist[k] == {DEB{1'b0}} && b_lvl[k]) begin
                    b_lvl[k] = 1'b0;
                end
                b_hist[k] = {b_hist[k][DEB-2:0], bin[k]};
            end
        end
        exp_o = {sh[0], sh[1], sh[2], sh[3], rise[0], rise[1],
                 (m_phase == 2 || m_phase == 3)};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset_state edge %0d: got %b want %b", i, obs, 7'b0);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL reset_idle edge %0d: got %b want %b", i, obs, exp_o);
            end
        end
    endtask

    task automatic test_right_hold();
        logic [63:0] got = '0;
        logic [63:0] oth = '0;
        logic [63:0] want = '0;
        want[4] = 1'b1; want[15] = 1'b1; want[19] = 1'b1; want[23] = 1'b1; want[27] = 1'b1;
        repeat_en = 1'b1;
        for (int i = 0; i < 42; i++) begin
            right = (i < 30);
            tick();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL right_hold edge %0d: got %b want %b", i, obs, exp_o);
            end
            got[i] = shft_R;
            oth[i] = shft_U | shft_D | shft_L | press_A | press_start;
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL right_hold_times: got %h want %h", got, want);
        end
        checks++;
        if (oth !== 64'd0) begin
            errors++;
            $display("FAIL right_hold_others: got %h want 0", oth);
        end
    endtask

    task automatic test_up_short();
        logic [63:0] got = '0;
        for (int i = 0; i < 12; i++) begin
            up = (i < 2);
            tick();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL up_short edge %0d: got %b want %b", i, obs, exp_o);
            end
            got[i] = |obs;
        end
        checks++;
        if (got !== 64'd0) begin
            errors++;
            $display("FAIL up_short_quiet: got %h want 0", got);
        end
    endtask

    task automatic test_up_left();
        logic [63:0] got_u = '0;
        logic [63:0] got_l = '0;
        logic [63:0] want_u = '0;
        logic [63:0] want_l = '0;
        want_u[4]  = 1'b1;
        want_l[19] = 1'b1;
        repeat_en = 1'b1;
        for (int i = 0; i < 44; i++) begin
            up   = (i < 10);
            left = (i < 30);
            tick();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL up_left edge %0d: got %b want %b", i, obs, exp_o);
            end
            got_u[i] = shft_U;
            got_l[i] = shft_L;
        end
        checks++;
        if (got_u !== want_u) begin
            errors++;
            $display("FAIL up_left_U_times: got %h want %h", got_u, want_u);
        end
        checks++;
        if (got_l !== want_l) begin
            errors++;
            $display("FAIL up_left_L_times: got %h want %h", got_l, want_l);
        end
    endtask

    task automatic test_down_norepeat();
        logic [63:0] got_d = '0;
        logic [63:0] got_a = '0;
        logic [63:0] want_d = '0;
        logic [63:0] want_a;
        want_d[4] = 1'b1;
        want_a = ((64'd1 << 44) - 64'd1) & ~((64'd1 << 4) - 64'd1);
        repeat_en = 1'b0;
        for (int i = 0; i < 52; i++) begin
            down = (i < 40);
            tick();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL down_norep edge %0d: got %b want %b", i, obs, exp_o);
            end
            got_d[i] = shft_D;
            got_a[i] = dir_active;
        end
        checks++;
        if (got_d !== want_d) begin
            errors++;
            $display("FAIL down_norep_times: got %h want %h", got_d, want_d);
        end
        checks++;
        if (got_a !== want_a) begin
            errors++;
            $display("FAIL down_norep_active: got %h want %h", got_a, want_a);
        end
        repeat_en = 1'b1;
    endtask

    task automatic test_left_glitch();
        logic [63:0] got = '0;
        logic [63:0] want = '0;
        want[4] = 1'b1; want[15] = 1'b1; want[19] = 1'b1; want[32] = 1'b1; want[36] = 1'b1;
        repeat_en = 1'b1;
        for (int i = 0; i < 52; i++) begin
            left = (i < 20) || (i >= 22 && i < 40);
            tick();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL left_glitch edge %0d: got %b want %b", i, obs, exp_o);
            end
            got[i] = shft_L;
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL left_glitch_times: got %h want %h", got, want);
        end
    endtask

    task automatic test_start_reset();
        logic [63:0] got = '0;
        logic [63:0] want = '0;
        want[8] = 1'b1;
        for (int i = 0; i < 34; i++) begin
            start   = (i < 20);
            reset_n = !(i == 2 || i == 3);
            tick();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL start_reset edge %0d: got %b want %b", i, obs, exp_o);
            end
            got[i] = press_start;
        end
        reset_n = 1'b1;
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL start_reset_times: got %h want %h", got, want);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 24; s++) begin
            repeat_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 80; i++) begin
                if (i < 66) begin
                    if ($urandom_range(0, 9) == 0)  up    = ~up;
                    if ($urandom_range(0, 9) == 0)  down  = ~down;
                    if ($urandom_range(0, 9) == 0)  left  = ~left;
                    if ($urandom_range(0, 9) == 0)  right = ~right;
                    if ($urandom_range(0, 6) == 0)  a     = ~a;
                    if ($urandom_range(0, 6) == 0)  start = ~start;
                end else begin
                    {up, down, left, right, a, start} = 6'b0;
                end
                tick();
                checks++;
                if (obs !== exp_o) begin
                    errors++;
                    $display("FAIL random s%0d edge %0d: got %b want %b", s, i, obs, exp_o);
                end
                checks++;
                if ($countones({shft_U, shft_D, shft_L, shft_R}) > 1) begin
                    errors++;
                    $display("FAIL random_onehot s%0d edge %0d: got %b want at most one",
                             s, i, {shft_U, shft_D, shft_L, shft_R});
                end
            end
        end
    endtask

    initial begin
        b_hist[0] = '0;
        b_hist[1] = '0;
        test_reset();
        test_right_hold();
        test_up_short();
        test_up_left();
        test_down_norepeat();
        test_left_glitch();
        test_start_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/n8_move_conditioner.md
Name: n8_move_conditioner

Overview:
- Conditions raw n8 controller levels (up/down/left/right/a/start, from the n8 controller driver) into single-cycle command pulses for the player-block and collision logic.
- Adds a press debounce and a release debounce, one-direction-at-a-time arbitration, and timed auto-repeat while a direction is held.
- Sits between the n8 driver and the player block. It replaces the per-button one-shot filters in the maze top level.

Parameters:
DEBOUNCE_CYC, 500000, cycles a level must be stable before a press or release is accepted (10 ms at 50 MHz)
HOLD_CYC, 25000000, cycles after the first pulse before auto-repeat starts (0.5 s)
REPEAT_CYC, 5000000, cycles between auto-repeat pulses (0.1 s)

Ports:
clk  in  1  system clock (CLOCK_50 at top)
reset_n  in  1  reset, asynchronous assert, active-low
up  in  1  raw level from n8 driver
down  in  1  raw level
left  in  1  raw level
right  in  1  raw level
a  in  1  raw level
start  in  1  raw level
repeat_en  in  1  1 = auto-repeat allowed; 0 = one pulse per press
shft_U  out  1  one-cycle move-up pulse
shft_D  out  1  one-cycle move-down pulse
shft_L  out  1  one-cycle move-left pulse
shft_R  out  1  one-cycle move-right pulse
press_A  out  1  one-cycle A pulse (no repeat)
press_start  out  1  one-cycle start pulse (no repeat)
dir_active  out  1  high while a direction is accepted and held

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: reset_n low clears all outputs, all counters and the latched direction to 0, and puts the FSM in IDLE. Reset mid-press aborts the press with no pulse. After release of reset, a held button is treated as a new press.
- Inputs are already synchronous to clk; no synchronizer is needed.
- Direction FSM states: IDLE, PRESS_DB, HOLD, REPEAT, RELEASE_DB. cur_dir is a 2-bit latched direction. cnt is a $clog2(max param)-bit counter that resets to 0 on every state entry.
  - IDLE: if any direction is high, latch the highest priority (up > down > left > right) into cur_dir and go to PRESS_DB.
  - PRESS_DB: if the cur_dir input drops, go to IDLE with no pulse. If cnt == DEBOUNCE_CYC-1, pulse cur_dir on the next cycle and go to HOLD.
  - HOLD: cur_dir low -> RELEASE_DB. Otherwise, if repeat_en and cnt == HOLD_CYC-1, emit a pulse and go to REPEAT. If repeat_en is low, cnt saturates at 0 and no pulse is emitted.
  - REPEAT: cur_dir low -> RELEASE_DB. If cnt == REPEAT_CYC-1, emit a pulse and restart cnt. repeat_en falling -> HOLD with no pulse.
  - RELEASE_DB: cur_dir high again -> HOLD (cnt = 0, no pulse). If cnt == DEBOUNCE_CYC-1 -> IDLE.
- Non-latched directions are ignored in every state except IDLE. A simultaneous press resolves by priority. A second direction pressed while holding is picked up only after the release debounce completes, if it is still held then.
- Pulses are registered and exactly one cycle wide. At most one of shft_U/D/L/R is high in any cycle.
- Latency: an input stable from cycle 0 gives a pulse in cycle DEBOUNCE_CYC.
- dir_active = 1 in HOLD, REPEAT and RELEASE_DB.
- a and start:
  - Each goes through an independent debouncer: the stable level updates after DEBOUNCE_CYC consecutive equal samples.
  - Rising edge of the stable level produces a one-cycle pulse. No repeat.
  - A/start pulses may coincide with direction pulses.
- Counter arithmetic is unsigned. Every compare is an equality test, so no wrap can occur. All parameters must be >= 2; violating this is illegal and is checked with an elaboration-time assertion.

Decomposition:
- Shared package n8_pkg holds:
  - typedef enum logic [2:0] for the FSM states
  - typedef enum logic [1:0] dir_t {DIR_U, DIR_D, DIR_L, DIR_R}
  - default timing constants DEB_10MS, HOLD_500MS, REP_100MS
- Sub-module n8_btn_debounce (params DEBOUNCE_CYC; ports clk, reset_n, in, level, rise_pulse) is instantiated twice, for a and start.
- The direction FSM stays inline.

Test Plan (DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=3, repeat_en=1 unless stated):
- right high from cycle 0, held 30 cycles:
  - shft_R pulses at cycles 4, 15, 19, 23, 27; no other outputs pulse.
- up high for 2 cycles, then low:
  - no pulse; FSM returns to IDLE.
- up and left rise in the same cycle:
  - only shft_U pulses, at cycle 4.
  - left still held after up releases and the release debounce completes (4 cycles) -> shft_L pulses 4 cycles after IDLE is re-entered.
- down held with repeat_en=0 for 40 cycles:
  - exactly one shft_D, at cycle 4; dir_active stays 1 until 4 cycles after release.
- left held to cycle 20, glitches low for 2 cycles, returns high:
  - no extra pulse from the glitch; FSM passes RELEASE_DB -> HOLD; next pulse 10 cycles after return.
- start held 20 cycles while reset_n pulses low at cycle 2:
  - all outputs stay 0 during reset; press_start pulses exactly once, 4 cycles after reset_n rises.
